ddr_rd_arbiter: RTL and testbench
=================================

Name: ddr_rd_arbiter

Overview:
- Shares one AXI read port (AR/R channels) to a DDR controller among N_REQ requesters. Requesters are PCI host reads and tile-side debug/log readers.
- Round-robin arbitration on AR, with a per-requester cap on outstanding bursts.
- Requester index is encoded into the upper bits of the downstream arid. R beats are routed back by that index.
- Provides drain/idle control so a debug snapshot can quiesce the port before reading state.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- IDX_W, $clog2(N_REQ), requester-index bits in the downstream ID.
- ID_W, 16, arid/rid width on both sides.
- MAX_OUTST, 8, maximum outstanding bursts per requester (1..255).
- DATA_W, 512, rdata width.

Ports:
- clk  in  1  clock; single clock domain.
- rstn  in  1  reset, asynchronous, active-low.
- req_arvalid  in  N_REQ  per-requester AR valid.
- req_arready  out  N_REQ  per-requester AR ready.
- req_araddr  in  N_REQ*64  per-requester AR address.
- req_arlen  in  N_REQ*8  per-requester AR burst length.
- req_arsize  in  N_REQ*3  per-requester AR size.
- req_arid  in  N_REQ*ID_W  per-requester AR ID; upper IDX_W bits must be 0.
- req_rvalid  out  N_REQ  per-requester R valid.
- req_rready  in  N_REQ  per-requester R ready.
- req_rdata  out  DATA_W  R data, shared bus.
- req_rid  out  ID_W  R ID, shared bus.
- req_rresp  out  2  R response, shared bus.
- req_rlast  out  1  R last, shared bus.
- ddr_arvalid  out  1  downstream AR valid.
- ddr_arready  in  1  downstream AR ready.
- ddr_araddr  out  64  downstream AR address.
- ddr_arlen  out  8  downstream AR burst length.
- ddr_arsize  out  3  downstream AR size.
- ddr_arid  out  ID_W  downstream AR ID (index-tagged).
- ddr_rvalid  in  1  downstream R valid.
- ddr_rready  out  1  downstream R ready.
- ddr_rdata  in  DATA_W  downstream R data.
- ddr_rid  in  ID_W  downstream R ID.
- ddr_rresp  in  2  downstream R response.
- ddr_rlast  in  1  downstream R last.
- drain  in  1  when high, no new AR grants.
- idle  out  1  AR output register empty and all outstanding counters 0.
- err_bad_rid  out  1  sticky; R beat seen with index >= N_REQ.

Behaviour:
- Reset (async assert, sync deassert by caller):
  - ddr_arvalid=0, all req_arready=0, all counters=0, RR pointer=0, err_bad_rid=0, idle=1.
- AR output register:
  - Holds one request. ddr_ar* are driven from the register only.
  - Register loads when empty, or when ddr_arvalid & ddr_arready in the same cycle (full throughput, 1 beat/cycle).
  - Contents are stable while ddr_arvalid=1 & !ddr_arready.
- Eligibility: requester i is eligible when req_arvalid[i] & cnt[i] < MAX_OUTST & !drain.
- Grant:
  - Combinational round-robin; search starts at ptr.
  - req_arready[g]=1 only for the winner g, and only if the register can load. All other req_arready bits are 0.
  - On a handshake with g: ptr <= (g+1) mod N_REQ and cnt[g]++. The register loads the request with ddr_arid = {g[IDX_W-1:0], req_arid[g][ID_W-IDX_W-1:0]}.
  - Latency: requester handshake in cycle t, ddr_arvalid=1 in cycle t+1.
- drain:
  - Blocks new grants from the same cycle it rises.
  - A request already in the register still issues.
  - idle = !ddr_arvalid & all cnt==0.
- R routing (combinational, zero latency):
  - idx = ddr_rid[ID_W-1:ID_W-IDX_W].
  - req_rvalid[idx] = ddr_rvalid; all other req_rvalid bits are 0.
  - ddr_rready = req_rready[idx].
  - req_rid = ddr_rid with the upper IDX_W bits zeroed. rdata, rresp and rlast pass through.
- Bad index (idx >= N_REQ):
  - ddr_rready=1 (beat is sunk), no req_rvalid asserted, err_bad_rid <= 1.
  - err_bad_rid is cleared only by reset.
- Counters:
  - cnt[i]-- on ddr_rvalid & ddr_rready & ddr_rlast with idx==i.
  - Increment and decrement on the same requester in the same cycle leave cnt unchanged.
  - cnt never exceeds MAX_OUTST: the cap is enforced at grant.
  - A decrement at 0 is illegal. Hold at 0 and flag err_bad_rid.
- Counter width: $clog2(MAX_OUTST+1).
- Cap release: a requester at MAX_OUTST becomes eligible again in the cycle after its last rlast handshake, because the count is registered.

Test Plan:
- Single requester 1, arid=0x0005, arlen=3 → ddr_arvalid 1 cycle later with ddr_arid=0x4005 (N_REQ=4). 4 R beats with rid=0x4005 → req_rvalid=4'b0010 each beat, req_rid=0x0005, idle=1 after rlast.
- All 4 requesters hold arvalid continuously with ddr_arready=1 → grant order 0,1,2,3,0,…, one grant per cycle, no bubbles.
- ddr_arready=0 for 5 cycles with a request held → ddr_ar* stable, no req_arready asserted. ddr_arready=1 → next grant proceeds the same cycle.
- Requester 2 issues 8 bursts with no R return (MAX_OUTST=8) → 9th request not granted while requester 0 is still granted. One rlast for requester 2 → requester 2 granted the following cycle.
- drain=1 with 3 bursts outstanding → no new grants, idle=0 until the third rlast, then idle=1 next cycle.
- R beat with rid upper bits=2'b11 at N_REQ=3 → ddr_rready=1, no req_rvalid, err_bad_rid=1 and it stays 1. Async rstn low mid-burst → all outputs return to reset values immediately.

Source files
------------

// File: rtl/ddr_rd_arbiter.sv
// Round-robin AXI read arbiter: N_REQ requesters share one AR/R port; the requester index travels in the upper arid bits.
// AR has 1-cycle latency through a single output register that stalls on ddr_arready; R is routed combinationally by index.
module ddr_rd_arbiter #(
  parameter int N_REQ     = 4,
  parameter int IDX_W     = $clog2(N_REQ),
  parameter int ID_W      = 16,
  parameter int MAX_OUTST = 8,
  parameter int DATA_W    = 512
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_REQ-1:0]        req_arvalid,
  output logic [N_REQ-1:0]        req_arready,
  input  logic [N_REQ*64-1:0]     req_araddr,
  input  logic [N_REQ*8-1:0]      req_arlen,
  input  logic [N_REQ*3-1:0]      req_arsize,
  input  logic [N_REQ*ID_W-1:0]   req_arid,
  output logic [N_REQ-1:0]        req_rvalid,
  input  logic [N_REQ-1:0]        req_rready,
  output logic [DATA_W-1:0]       req_rdata,
  output logic [ID_W-1:0]         req_rid,
  output logic [1:0]              req_rresp,
  output logic                    req_rlast,
  output logic                    ddr_arvalid,
  input  logic                    ddr_arready,
  output logic [63:0]             ddr_araddr,
  output logic [7:0]              ddr_arlen,
  output logic [2:0]              ddr_arsize,
  output logic [ID_W-1:0]         ddr_arid,
  input  logic                    ddr_rvalid,
  output logic                    ddr_rready,
  input  logic [DATA_W-1:0]       ddr_rdata,
  input  logic [ID_W-1:0]         ddr_rid,
  input  logic [1:0]              ddr_rresp,
  input  logic                    ddr_rlast,
  input  logic                    drain,
  output logic                    idle,
  output logic                    err_bad_rid
);
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int LID_W = ID_W - IDX_W;

  logic [CNT_W-1:0] cnt [N_REQ];
  logic [IDX_W-1:0] ptr;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] cnt_inc;
  logic [N_REQ-1:0] cnt_dec;
  logic             underflow;
  logic             gnt_found;
  logic [IDX_W-1:0] gnt_idx;
  logic             can_load;
  logic             ar_hs;
  logic [IDX_W-1:0] r_idx;
  logic             r_bad;
  logic             r_done;
  logic             any_out;
  logic [63:0]      sel_addr;
  logic [7:0]       sel_len;
  logic [2:0]       sel_size;
  logic [LID_W-1:0] sel_id;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = req_arvalid[i] && (cnt[i] < CNT_W'(MAX_OUTST)) && !drain;
    end
  end

  // Winner is the eligible requester at the smallest rotational distance from ptr.
  always_comb begin
    int best_d;
    best_d    = N_REQ;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      int d;
      d = (i + N_REQ - int'(ptr)) % N_REQ;
      if (elig[i] && d < best_d) begin
        best_d    = d;
        gnt_found = 1'b1;
        gnt_idx   = IDX_W'(i);
      end
    end
  end

  assign can_load = !ddr_arvalid || ddr_arready;
  assign ar_hs    = gnt_found && can_load && rstn;

  always_comb begin
    req_arready = '0;
    sel_addr    = '0;
    sel_len     = '0;
    sel_size    = '0;
    sel_id      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        req_arready[i] = ar_hs;
        sel_addr       = req_araddr[i*64 +: 64];
        sel_len        = req_arlen[i*8 +: 8];
        sel_size       = req_arsize[i*3 +: 3];
        sel_id         = req_arid[i*ID_W +: LID_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ddr_arvalid <= 1'b0;
      ddr_araddr  <= '0;
      ddr_arlen   <= '0;
      ddr_arsize  <= '0;
      ddr_arid    <= '0;
    end else if (can_load) begin
      ddr_arvalid <= ar_hs;
      if (ar_hs) begin
        ddr_araddr <= sel_addr;
        ddr_arlen  <= sel_len;
        ddr_arsize <= sel_size;
        ddr_arid   <= {gnt_idx, sel_id};
      end
    end
  end

  // R routing; an index with no matching requester is sunk and flagged.
  assign r_idx = ddr_rid[ID_W-1 -: IDX_W];

  always_comb begin
    r_bad      = 1'b1;
    req_rvalid = '0;
    ddr_rready = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_idx == IDX_W'(i)) begin
        r_bad         = 1'b0;
        req_rvalid[i] = ddr_rvalid;
        ddr_rready    = req_rready[i];
      end
    end
  end

  assign req_rid   = {{IDX_W{1'b0}}, ddr_rid[LID_W-1:0]};
  assign req_rdata = ddr_rdata;
  assign req_rresp = ddr_rresp;
  assign req_rlast = ddr_rlast;
  assign r_done    = ddr_rvalid && ddr_rready && ddr_rlast && !r_bad;

  always_comb begin
    cnt_inc   = '0;
    cnt_dec   = '0;
    underflow = 1'b0;
    any_out   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cnt_inc[i] = ar_hs && (gnt_idx == IDX_W'(i));
      if (r_done && (r_idx == IDX_W'(i))) begin
        if (cnt[i] == '0) underflow = 1'b1;
        else              cnt_dec[i] = 1'b1;
      end
      if (cnt[i] != '0) any_out = 1'b1;
    end
  end

  assign idle = !ddr_arvalid && !any_out;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
      ptr         <= '0;
      err_bad_rid <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (cnt_inc[i] && !cnt_dec[i])      cnt[i] <= cnt[i] + CNT_W'(1);
        else if (!cnt_inc[i] && cnt_dec[i]) cnt[i] <= cnt[i] - CNT_W'(1);
      end
      if (ar_hs) ptr <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
      if ((ddr_rvalid && r_bad) || underflow) err_bad_rid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Bench for ddr_rd_arbiter: directed sequences, a routing vector table and random traffic against a queue-based model.
module tb_ddr_rd_arbiter;
  localparam int N    = 4;
  localparam int IDW  = 16;
  localparam int MO   = 8;
  localparam int DW   = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn;
  logic [N-1:0]      req_arvalid, req_arready, req_rvalid, req_rready;
  logic [N*64-1:0]   req_araddr;
  logic [N*8-1:0]    req_arlen;
  logic [N*3-1:0]    req_arsize;
  logic [N*IDW-1:0]  req_arid;
  logic [DW-1:0]     req_rdata, ddr_rdata;
  logic [IDW-1:0]    req_rid, ddr_arid, ddr_rid;
  logic [1:0]        req_rresp, ddr_rresp;
  logic              req_rlast, ddr_arvalid, ddr_arready, ddr_rvalid, ddr_rready, ddr_rlast;
  logic [63:0]       ddr_araddr;
  logic [7:0]        ddr_arlen;
  logic [2:0]        ddr_arsize;
  logic              drain, idle, err_bad_rid;

  // Second instance with a non-power-of-two requester count, used only for the bad-index path.
  logic [2:0]        d3_arready, d3_rvalid, d3_rready;
  logic [DW-1:0]     d3_rdata;
  logic [IDW-1:0]    d3_rid, d3_arid, d3_ddr_rid;
  logic [1:0]        d3_rresp;
  logic              d3_rlast, d3_arvalid, d3_ddr_rvalid, d3_ddr_rready, d3_ddr_rlast, d3_idle, d3_err;
  logic [63:0]       d3_araddr;
  logic [7:0]        d3_arlen;
  logic [2:0]        d3_arsize;

  ddr_rd_arbiter #(.N_REQ(N), .ID_W(IDW), .MAX_OUTST(MO), .DATA_W(DW)) u_dut (
    .clk(clk), .rstn(rstn),
    .req_arvalid(req_arvalid), .req_arready(req_arready), .req_araddr(req_araddr),
    .req_arlen(req_arlen), .req_arsize(req_arsize), .req_arid(req_arid),
    .req_rvalid(req_rvalid), .req_rready(req_rready), .req_rdata(req_rdata),
    .req_rid(req_rid), .req_rresp(req_rresp), .req_rlast(req_rlast),
    .ddr_arvalid(ddr_arvalid), .ddr_arready(ddr_arready), .ddr_araddr(ddr_araddr),
    .ddr_arlen(ddr_arlen), .ddr_arsize(ddr_arsize), .ddr_arid(ddr_arid),
    .ddr_rvalid(ddr_rvalid), .ddr_rready(ddr_rready), .ddr_rdata(ddr_rdata),
    .ddr_rid(ddr_rid), .ddr_rresp(ddr_rresp), .ddr_rlast(ddr_rlast),
    .drain(drain), .idle(idle), .err_bad_rid(err_bad_rid)
  );

  ddr_rd_arbiter #(.N_REQ(3), .ID_W(IDW), .MAX_OUTST(2), .DATA_W(DW)) u_dut3 (
    .clk(clk), .rstn(rstn),
    .req_arvalid(3'b000), .req_arready(d3_arready), .req_araddr(192'd0),
    .req_arlen(24'd0), .req_arsize(9'd0), .req_arid(48'd0),
    .req_rvalid(d3_rvalid), .req_rready(d3_rready), .req_rdata(d3_rdata),
    .req_rid(d3_rid), .req_rresp(d3_rresp), .req_rlast(d3_rlast),
    .ddr_arvalid(d3_arvalid), .ddr_arready(1'b0), .ddr_araddr(d3_araddr),
    .ddr_arlen(d3_arlen), .ddr_arsize(d3_arsize), .ddr_arid(d3_arid),
    .ddr_rvalid(d3_ddr_rvalid), .ddr_rready(d3_ddr_rready), .ddr_rdata('0),
    .ddr_rid(d3_ddr_rid), .ddr_rresp(2'b00), .ddr_rlast(d3_ddr_rlast),
    .drain(1'b0), .idle(d3_idle), .err_bad_rid(d3_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: outstanding counts per requester, a pointer, one-deep AR slot, sticky error.
  int          m_cnt [N];
  int          m_ptr;
  bit          m_rv;
  logic [63:0] m_addr;
  logic [7:0]  m_len;
  logic [2:0]  m_size;
  logic [15:0] m_id;
  bit          m_err;
  int          m_w;
  logic [N-1:0] e_arready, e_rvalid;
  logic        e_rready;
  logic [15:0] e_rid;
  bit          e_idle;
  logic [15:0] pend_id [$];
  int          pend_len [$];

  function automatic void m_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_ptr = 0; m_rv = 0; m_err = 0;
    m_addr = '0; m_len = '0; m_size = '0; m_id = '0;
    pend_id.delete(); pend_len.delete();
  endfunction

  function automatic void m_eval();
    int p, ridx, sum;
    m_w = -1;
    p = m_ptr;
    repeat (N) begin
      if (m_w < 0 && req_arvalid[p] && m_cnt[p] < MO && !drain) m_w = p;
      p = (p + 1) % N;
    end
    e_arready = '0;
    if (m_w >= 0 && (!m_rv || ddr_arready)) e_arready[m_w] = 1'b1;
    ridx = int'(ddr_rid[15:14]);
    e_rvalid = '0;
    if (ddr_rvalid) e_rvalid[ridx] = 1'b1;
    e_rready = req_rready[ridx];
    e_rid    = {2'b00, ddr_rid[13:0]};
    sum = 0;
    foreach (m_cnt[i]) sum += m_cnt[i];
    e_idle = !m_rv && (sum == 0);
  endfunction

  function automatic void m_step();
    int ridx;
    ridx = int'(ddr_rid[15:14]);
    if (ddr_rvalid && e_rready && ddr_rlast) begin
      if (m_cnt[ridx] > 0) m_cnt[ridx]--;
      else m_err = 1;
    end
    if (m_rv && ddr_arready) begin
      pend_id.push_back(m_id);
      pend_len.push_back(int'(m_len));
      m_rv = 0;
    end
    if (e_arready != '0) begin
      m_rv   = 1;
      m_addr = req_araddr[m_w*64 +: 64];
      m_len  = req_arlen[m_w*8 +: 8];
      m_size = req_arsize[m_w*3 +: 3];
      m_id   = {m_w[1:0], req_arid[m_w*16 +: 14]};
      m_cnt[m_w]++;
      m_ptr  = (m_w + 1) % N;
    end
  endfunction

  task automatic settle();
    #1;
    m_eval();
    chk("arready", req_arready, e_arready);
    chk("ddr_arvalid", ddr_arvalid, m_rv);
    if (m_rv) begin
      chk("ddr_arid", ddr_arid, m_id);
      chk("ddr_araddr", ddr_araddr, m_addr);
      chk("ddr_arlen", ddr_arlen, m_len);
      chk("ddr_arsize", ddr_arsize, m_size);
    end
    chk("req_rvalid", req_rvalid, e_rvalid);
    chk("ddr_rready", ddr_rready, e_rready);
    chk("req_rid", req_rid, e_rid);
    chk("req_rlast", req_rlast, ddr_rlast);
    chk("req_rresp", req_rresp, ddr_rresp);
    chk("idle", idle, e_idle);
    chk("err_bad_rid", err_bad_rid, m_err);
  endtask

  task automatic adv();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic cyc();
    settle();
    adv();
  endtask

  task automatic set_req(input int i, input logic [63:0] a, input logic [7:0] l,
                         input logic [2:0] s, input logic [15:0] id);
    req_araddr[i*64 +: 64] = a;
    req_arlen[i*8 +: 8]    = l;
    req_arsize[i*3 +: 3]   = s;
    req_arid[i*16 +: 16]   = id;
  endtask

  task automatic clear_inputs();
    req_arvalid = '0; req_araddr = '0; req_arlen = '0; req_arsize = '0; req_arid = '0;
    req_rready = '0; ddr_arready = 0; ddr_rvalid = 0; ddr_rdata = '0; ddr_rid = '0;
    ddr_rresp = '0; ddr_rlast = 0; drain = 0;
    d3_rready = '0; d3_ddr_rvalid = 0; d3_ddr_rid = '0; d3_ddr_rlast = 0;
  endtask

  task automatic do_reset();
    rstn = 0;
    clear_inputs();
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rstn = 1;
  endtask

  typedef struct {
    logic        rv;
    logic [15:0] rid;
    logic [3:0]  rr;
    logic [3:0]  exp_rv;
    logic        exp_rdy;
    logic [15:0] exp_rid;
  } rvec_t;

  rvec_t tbl [7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] dat;
    int beat;
    bit hs, was_last, drained;

    tbl[0] = '{1'b1, 16'h4005, 4'b0010, 4'b0010, 1'b1, 16'h0005};
    tbl[1] = '{1'b1, 16'h0123, 4'b1110, 4'b0001, 1'b0, 16'h0123};
    tbl[2] = '{1'b1, 16'hC0FF, 4'b1000, 4'b1000, 1'b1, 16'h00FF};
    tbl[3] = '{1'b0, 16'h8ABC, 4'b0100, 4'b0000, 1'b1, 16'h0ABC};
    tbl[4] = '{1'b1, 16'h8ABC, 4'b1011, 4'b0100, 1'b0, 16'h0ABC};
    tbl[5] = '{1'b1, 16'h7FFF, 4'b0010, 4'b0010, 1'b1, 16'h3FFF};
    tbl[6] = '{1'b1, 16'hFFFF, 4'b0111, 4'b1000, 1'b0, 16'h3FFF};

    // Reset values, with every requester asking for the port.
    rstn = 0;
    clear_inputs();
    m_reset();
    req_arvalid = '1;
    #1;
    chk("rst_arready", req_arready, 4'b0000);
    chk("rst_arvalid", ddr_arvalid, 1'b0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_err", err_bad_rid, 1'b0);
    do_reset();

    // Combinational R routing table (rlast low so counters stay put).
    foreach (tbl[k]) begin
      dat = {16{$urandom}};
      ddr_rvalid = tbl[k].rv; ddr_rid = tbl[k].rid; req_rready = tbl[k].rr;
      ddr_rdata = dat; ddr_rresp = 2'(k); ddr_rlast = 0;
      settle();
      chk("tbl_rvalid", req_rvalid, tbl[k].exp_rv);
      chk("tbl_rready", ddr_rready, tbl[k].exp_rdy);
      chk("tbl_rid", req_rid, tbl[k].exp_rid);
      chk("tbl_rdata_lo", req_rdata[63:0], dat[63:0]);
      chk("tbl_rdata_hi", req_rdata[DW-1 -: 64], dat[DW-1 -: 64]);
      adv();
    end

    // Single requester 1: handshake, then index-tagged AR one cycle later, then 4 routed beats.
    do_reset();
    set_req(1, 64'h1000, 8'd3, 3'd6, 16'h0005);
    req_arvalid = 4'b0010;
    settle();
    chk("s1_arready", req_arready, 4'b0010);
    adv();
    req_arvalid = '0;
    ddr_arready = 1;
    settle();
    chk("s1_arvalid", ddr_arvalid, 1'b1);
    chk("s1_arid", ddr_arid, 16'h4005);
    chk("s1_arlen", ddr_arlen, 8'd3);
    adv();
    ddr_arready = 0;
    for (int b = 0; b < 4; b++) begin
      ddr_rvalid = 1; ddr_rid = 16'h4005; ddr_rlast = (b == 3); req_rready = 4'b0010;
      settle();
      chk("s1_rvalid", req_rvalid, 4'b0010);
      chk("s1_rid", req_rid, 16'h0005);
      chk("s1_idle_busy", idle, 1'b0);
      adv();
    end
    ddr_rvalid = 0; ddr_rlast = 0;
    settle();
    chk("s1_idle", idle, 1'b1);
    adv();

    // All four requesting with ddr_arready high: 0,1,2,3,0,... one per cycle.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 64'(i) << 12, 8'd0, 3'd5, 16'(i));
    req_arvalid = '1;
    ddr_arready = 1;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("s2_grant", req_arready, 4'b0001 << (k % 4));
      if (k > 0) chk("s2_nobubble", ddr_arvalid, 1'b1);
      adv();
    end

    // Downstream stall: register contents hold, no grants, resume in the same cycle arready returns.
    do_reset();
    set_req(0, 64'hABCD_0000, 8'd7, 3'd6, 16'h0042);
    req_arvalid = 4'b0001;
    settle();
    chk("s3_first", req_arready, 4'b0001);
    adv();
    set_req(0, 64'h5555, 8'd1, 3'd2, 16'h0011);
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("s3_stall_rdy", req_arready, 4'b0000);
      chk("s3_stall_id", ddr_arid, 16'h0042);
      chk("s3_stall_addr", ddr_araddr, 64'hABCD_0000);
      adv();
    end
    ddr_arready = 1;
    settle();
    chk("s3_resume", req_arready, 4'b0001);
    adv();
    settle();
    chk("s3_next_id", ddr_arid, 16'h0011);
    adv();

    // Outstanding cap on requester 2, other requesters unaffected, release one cycle after rlast.
    do_reset();
    set_req(2, 64'h2000, 8'd0, 3'd6, 16'h0002);
    set_req(0, 64'h0100, 8'd0, 3'd6, 16'h0007);
    req_arvalid = 4'b0100;
    ddr_arready = 1;
    for (int k = 0; k < MO; k++) begin
      settle();
      chk("s4_fill", req_arready, 4'b0100);
      adv();
    end
    req_arvalid = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("s4_capped", req_arready, 4'b0001);
      adv();
    end
    req_arvalid = 4'b0100;
    ddr_rvalid = 1; ddr_rid = 16'h8002; ddr_rlast = 1; req_rready = 4'b0100;
    settle();
    chk("s4_same_cycle", req_arready, 4'b0000);
    adv();
    ddr_rvalid = 0; ddr_rlast = 0;
    settle();
    chk("s4_release", req_arready, 4'b0100);
    adv();

    // Drain with 3 bursts outstanding.
    do_reset();
    set_req(3, 64'h3000, 8'd0, 3'd6, 16'h0003);
    req_arvalid = 4'b1000;
    ddr_arready = 1;
    repeat (3) cyc();
    drain = 1;
    req_arvalid = '1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("s5_nogrant", req_arready, 4'b0000);
      chk("s5_busy", idle, 1'b0);
      adv();
    end
    req_rready = 4'b1000;
    for (int b = 0; b < 3; b++) begin
      ddr_rvalid = 1; ddr_rid = 16'hC003; ddr_rlast = 1;
      settle();
      chk("s5_idle_busy", idle, 1'b0);
      adv();
    end
    ddr_rvalid = 0; ddr_rlast = 0;
    settle();
    chk("s5_idle", idle, 1'b1);
    adv();
    drain = 0; req_arvalid = '0;

    // Bad index on the 3-requester instance: sunk, not routed, sticky error.
    d3_ddr_rvalid = 1; d3_ddr_rid = 16'h4001; d3_rready = 3'b101; d3_ddr_rlast = 0;
    settle();
    chk("d3_good_rvalid", d3_rvalid, 3'b010);
    chk("d3_good_rready", d3_ddr_rready, 1'b0);
    adv();
    d3_ddr_rid = 16'hC123; d3_rready = 3'b000;
    settle();
    chk("d3_bad_rready", d3_ddr_rready, 1'b1);
    chk("d3_bad_rvalid", d3_rvalid, 3'b000);
    chk("d3_err_pre", d3_err, 1'b0);
    adv();
    d3_ddr_rvalid = 0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("d3_err_sticky", d3_err, 1'b1);
      adv();
    end

    // Asynchronous reset in the middle of activity.
    set_req(0, 64'h0F00, 8'd2, 3'd6, 16'h0009);
    set_req(1, 64'h0F40, 8'd2, 3'd6, 16'h000A);
    req_arvalid = 4'b0011;
    ddr_arready = 0;
    cyc();
    cyc();
    ddr_rvalid = 1; ddr_rid = 16'h0009; req_rready = '1;
    #2;
    rstn = 0;
    #1;
    chk("ar_rst_arvalid", ddr_arvalid, 1'b0);
    chk("ar_rst_arready", req_arready, 4'b0000);
    chk("ar_rst_idle", idle, 1'b1);
    chk("ar_rst_err3", d3_err, 1'b0);
    @(negedge clk);
    do_reset();

    // Random traffic against the model; R beats come back in order for issued bursts.
    beat = 0;
    for (int c = 0; c < 3000; c++) begin
      req_arvalid = 4'($urandom);
      for (int i = 0; i < N; i++)
        set_req(i, {$urandom, $urandom}, 8'($urandom_range(0, 3)), 3'($urandom), 16'($urandom_range(0, 16383)));
      drain       = ($urandom_range(0, 19) == 0);
      ddr_arready = ($urandom_range(0, 3) != 0);
      req_rready  = 4'($urandom);
      ddr_rdata   = {16{$urandom}};
      ddr_rresp   = 2'($urandom);
      if (pend_id.size() > 0 && $urandom_range(0, 2) != 0) begin
        ddr_rvalid = 1;
        ddr_rid    = pend_id[0];
        ddr_rlast  = (beat == pend_len[0]);
      end else begin
        ddr_rvalid = 0;
        ddr_rid    = 16'($urandom);
        ddr_rlast  = 0;
      end
      settle();
      hs = ddr_rvalid && e_rready;
      was_last = ddr_rlast;
      adv();
      if (hs) begin
        if (was_last) begin
          void'(pend_id.pop_front());
          void'(pend_len.pop_front());
          beat = 0;
        end else begin
          beat++;
        end
      end
    end

    // Quiesce: drain, return every outstanding beat, expect idle within a bounded time.
    drain = 1; req_arvalid = '0; ddr_arready = 1; req_rready = '1;
    drained = 0;
    for (int c = 0; c < 2000 && !drained; c++) begin
      if (pend_id.size() > 0) begin
        ddr_rvalid = 1; ddr_rid = pend_id[0]; ddr_rlast = (beat == pend_len[0]);
      end else begin
        ddr_rvalid = 0; ddr_rlast = 0;
      end
      settle();
      if (!ddr_rvalid && !m_rv && pend_id.size() == 0) drained = 1;
      hs = ddr_rvalid && e_rready;
      was_last = ddr_rlast;
      adv();
      if (hs) begin
        if (was_last) begin
          void'(pend_id.pop_front());
          void'(pend_len.pop_front());
          beat = 0;
        end else begin
          beat++;
        end
      end
    end
    chk("final_drained", drained, 1'b1);
    chk("final_idle", idle, 1'b1);
    chk("final_err", err_bad_rid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
